// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM: one shared period counter, per-channel clamped pulse
// widths and enables that only take effect at period boundaries.

module servo_pwm_lane #(
    parameter int CNT_W         = 32,
    parameter int DEFAULT_PULSE = 75000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boundary,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_width,
    input  logic             en_req,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm
);
    localparam logic [CNT_W-1:0] DEF_W = CNT_W'(DEFAULT_PULSE);

    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] act;
    logic             en_act;

    // act/en_act are frozen for a whole period; a write landing on the boundary
    // cycle bypasses pend so it still makes the very next period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend   <= DEF_W;
            act    <= DEF_W;
            en_act <= 1'b0;
            pwm    <= 1'b0;
        end else begin
            if (wr_hit)
                pend <= wr_width;
            if (boundary) begin
                act    <= wr_hit ? wr_width : pend;
                en_act <= en_req;
            end
            pwm <= en_act && (cnt < act);
        end
    end
endmodule

module servo_pwm_multi #(
    parameter int CHANNELS      = 4,
    parameter int CNT_W         = 32,
    parameter int PERIOD        = 1000000,
    parameter int MIN_PULSE     = 50000,
    parameter int MAX_PULSE     = 125000,
    parameter int DEFAULT_PULSE = 75000,
    parameter int AW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [CNT_W-1:0]    wr_data,
    input  logic [CHANNELS-1:0] ch_en,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start,
    output logic                wr_clamped,
    output logic                wr_err,
    output logic                ledres
);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_PULSE);
    localparam logic [AW:0]      NCH   = (AW+1)'(CHANNELS);

    logic [CNT_W-1:0]    cnt;
    logic                boundary;
    logic                addr_ok;
    logic                below;
    logic                above;
    logic [CNT_W-1:0]    wr_width;
    logic [CHANNELS-1:0] wr_hit;

    assign boundary = (cnt == LAST);
    assign addr_ok  = ({1'b0, wr_addr} < NCH);
    assign below    = (wr_data < MIN_W);
    assign above    = (wr_data > MAX_W);
    assign wr_width = below ? MIN_W : (above ? MAX_W : wr_data);

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < CHANNELS; i++)
            wr_hit[i] = wr_en && addr_ok && (wr_addr == AW'(i));
    end

    // period_start is registered from cnt==0 so it lines up with the
    // registered rising edge of every pwm_out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            period_start <= 1'b0;
            wr_clamped   <= 1'b0;
            wr_err       <= 1'b0;
            ledres       <= 1'b1;
        end else begin
            cnt          <= boundary ? '0 : cnt + 1'b1;
            period_start <= (cnt == '0);
            wr_clamped   <= wr_en && addr_ok && (below || above);
            wr_err       <= wr_en && !addr_ok;
            ledres       <= 1'b0;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        servo_pwm_lane #(
            .CNT_W        (CNT_W),
            .DEFAULT_PULSE(DEFAULT_PULSE)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .boundary(boundary),
            .wr_hit  (wr_hit[g]),
            .wr_width(wr_width),
            .en_req  (ch_en[g]),
            .cnt     (cnt),
            .pwm     (pwm_out[g])
        );
    end
endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: a 4-channel and a 3-channel instance share stimulus;
// an edge-count model plus per-period pulse-width tallies give expected values.

module tb_servo_pwm_multi;
    localparam int P    = 100;
    localparam int MINP = 5;
    localparam int MAXP = 20;
    localparam int DEFP = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  ch_en = '0;
    logic [3:0]  pwm_out;
    logic        period_start, wr_clamped, wr_err, ledres;
    logic [2:0]  pwm3;
    logic        ps3, clamp3, err3, led3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    servo_pwm_multi #(.CHANNELS(4), .CNT_W(32), .PERIOD(P), .MIN_PULSE(MINP),
                      .MAX_PULSE(MAXP), .DEFAULT_PULSE(DEFP)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ch_en(ch_en), .pwm_out(pwm_out), .period_start(period_start),
        .wr_clamped(wr_clamped), .wr_err(wr_err), .ledres(ledres));

    servo_pwm_multi #(.CHANNELS(3), .CNT_W(32), .PERIOD(P), .MIN_PULSE(MINP),
                      .MAX_PULSE(MAXP), .DEFAULT_PULSE(DEFP)) dut3 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ch_en(ch_en[2:0]), .pwm_out(pwm3), .period_start(ps3),
        .wr_clamped(clamp3), .wr_err(err3), .ledres(led3));

    // Reference model: m_k counts clock edges since reset release, so the
    // position within the period is simply m_k mod P.
    int         m_k;
    int         m_pos;
    int         m_pend [4];
    int         m_act  [4];
    logic [3:0] m_en;
    logic [3:0] e_pwm;
    logic       e_ps, e_clamp, e_clamp3, e_err3, e_led;

    assign m_pos = m_k % P;

    function automatic int clampf(input int d);
        return (d < MINP) ? MINP : ((d > MAXP) ? MAXP : d);
    endfunction

    function automatic int next_pend(input int ch);
        return (wr_en && int'(wr_addr) == ch) ? clampf(int'(wr_data)) : m_pend[ch];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k      <= 0;
            m_en     <= '0;
            e_pwm    <= '0;
            e_ps     <= 1'b0;
            e_clamp  <= 1'b0;
            e_clamp3 <= 1'b0;
            e_err3   <= 1'b0;
            e_led    <= 1'b1;
            for (int ch = 0; ch < 4; ch++) begin
                m_pend[ch] <= DEFP;
                m_act[ch]  <= DEFP;
            end
        end else begin
            m_k      <= m_k + 1;
            e_led    <= 1'b0;
            e_ps     <= (m_pos == 0);
            e_clamp  <= wr_en && (clampf(int'(wr_data)) != int'(wr_data));
            e_clamp3 <= wr_en && (wr_addr != 2'd3) && (clampf(int'(wr_data)) != int'(wr_data));
            e_err3   <= wr_en && (wr_addr == 2'd3);
            for (int ch = 0; ch < 4; ch++) begin
                e_pwm[ch]  <= m_en[ch] && (m_pos < m_act[ch]);
                m_pend[ch] <= next_pend(ch);
                if (m_pos == P - 1)
                    m_act[ch] <= next_pend(ch);
            end
            if (m_pos == P - 1)
                m_en <= ch_en;
        end
    end

    // Per-period tallies gathered by run_period.
    int         hi  [4];
    int         hi3 [3];
    int         clamp_cnt, err3_cnt, ps_cnt, bad, bad_p;
    logic [3:0] first_pwm;
    logic [9:0] bad_got, bad_exp;

    // Runs exactly one period starting from the cycle where cnt==0 is next.
    // Optional single write at position wpos and ch_en update at position en_pos.
    task automatic run_period(input int wpos, input int waddr, input int wdata,
                              input logic [3:0] en_new, input int en_pos);
        logic [9:0] got, exp;
        for (int ch = 0; ch < 4; ch++) hi[ch] = 0;
        for (int ch = 0; ch < 3; ch++) hi3[ch] = 0;
        clamp_cnt = 0; err3_cnt = 0; ps_cnt = 0; bad = 0; bad_p = -1;
        for (int p = 0; p < P; p++) begin
            wr_en   = (p == wpos);
            wr_addr = 2'(waddr);
            wr_data = 32'(wdata);
            if (p == en_pos) ch_en = en_new;
            @(negedge clk);
            got = {pwm_out, period_start, wr_clamped, wr_err, pwm3[0], clamp3, err3};
            exp = {e_pwm, e_ps, e_clamp, 1'b0, e_pwm[0], e_clamp3, e_err3};
            if (got !== exp || pwm3 !== e_pwm[2:0] || ps3 !== e_ps) begin
                if (bad == 0) begin bad_p = p; bad_got = got; bad_exp = exp; end
                bad++;
            end
            if (p == 0) first_pwm = pwm_out;
            for (int ch = 0; ch < 4; ch++) hi[ch] += int'(pwm_out[ch]);
            for (int ch = 0; ch < 3; ch++) hi3[ch] += int'(pwm3[ch]);
            clamp_cnt += int'(wr_clamped);
            err3_cnt  += int'(err3);
            ps_cnt    += int'(period_start);
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        ch_en = 4'hF;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pwm_out, period_start, wr_clamped, wr_err, ledres} !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_state: got %b required 00000001",
                     {pwm_out, period_start, wr_clamped, wr_err, ledres});
        end
        n_checks++;
        if ({pwm3, ps3, clamp3, err3, led3} !== 7'b000_0001) begin
            n_fail++;
            $display("FAIL reset_state3: got %b required 0000001", {pwm3, ps3, clamp3, err3, led3});
        end
        reset = 1'b1;
    endtask

    task automatic test_first_period;
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL first_model: %0d bad cycles, first p=%0d got %b required %b", bad, bad_p, bad_got, bad_exp);
        end
        n_checks++;
        if (hi[0] + hi[1] + hi[2] + hi[3] !== 0) begin
            n_fail++;
            $display("FAIL first_low: high cycles %0d %0d %0d %0d required 0", hi[0], hi[1], hi[2], hi[3]);
        end
        n_checks++;
        if (ps_cnt !== 1) begin
            n_fail++;
            $display("FAIL first_ps: period_start pulses %0d required 1", ps_cnt);
        end
    endtask

    task automatic test_steady;
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL steady_model: %0d bad cycles, first p=%0d got %b required %b", bad, bad_p, bad_got, bad_exp);
        end
        for (int ch = 0; ch < 4; ch++) begin
            n_checks++;
            if (hi[ch] !== DEFP) begin
                n_fail++;
                $display("FAIL steady_width ch%0d: %0d required %0d", ch, hi[ch], DEFP);
            end
        end
        n_checks++;
        if (first_pwm !== 4'hF || ps_cnt !== 1) begin
            n_fail++;
            $display("FAIL steady_align: pwm at start %b ps %0d required 1111 and 1", first_pwm, ps_cnt);
        end
    endtask

    task automatic test_write_mid;
        run_period(50, 2, 15, 4'hF, -1);
        n_checks++;
        if (hi[2] !== DEFP || clamp_cnt !== 0 || bad !== 0) begin
            n_fail++;
            $display("FAIL mid_write_cur: ch2 %0d clamps %0d bad %0d required %0d 0 0", hi[2], clamp_cnt, bad, DEFP);
        end
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (hi[0] !== 10 || hi[1] !== 10 || hi[2] !== 15 || hi[3] !== 10 || bad !== 0) begin
            n_fail++;
            $display("FAIL mid_write_next: widths %0d %0d %0d %0d bad %0d required 10 10 15 10 0", hi[0], hi[1], hi[2], hi[3], bad);
        end
    endtask

    task automatic test_clamp;
        run_period(30, 1, 2, 4'hF, -1);
        n_checks++;
        if (clamp_cnt !== 1 || hi[1] !== 10 || bad !== 0) begin
            n_fail++;
            $display("FAIL clamp_low: clamps %0d ch1 %0d bad %0d required 1 10 0", clamp_cnt, hi[1], bad);
        end
        run_period(60, 3, 50, 4'hF, -1);
        n_checks++;
        if (clamp_cnt !== 1 || hi[1] !== MINP || hi[3] !== 10 || bad !== 0) begin
            n_fail++;
            $display("FAIL clamp_high: clamps %0d ch1 %0d ch3 %0d bad %0d required 1 5 10 0", clamp_cnt, hi[1], hi[3], bad);
        end
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (hi[3] !== MAXP || hi[1] !== MINP || bad !== 0) begin
            n_fail++;
            $display("FAIL clamp_applied: ch1 %0d ch3 %0d bad %0d required 5 20 0", hi[1], hi[3], bad);
        end
    endtask

    task automatic test_addr_err;
        run_period(20, 3, 7, 4'hF, -1);
        n_checks++;
        if (err3_cnt !== 1 || bad !== 0) begin
            n_fail++;
            $display("FAIL addr_err: wr_err pulses %0d bad %0d required 1 0", err3_cnt, bad);
        end
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (hi3[0] !== 10 || hi3[1] !== 5 || hi3[2] !== 15 || err3_cnt !== 0) begin
            n_fail++;
            $display("FAIL addr_err_nochange: widths %0d %0d %0d errs %0d required 10 5 15 0", hi3[0], hi3[1], hi3[2], err3_cnt);
        end
    endtask

    task automatic test_boundary;
        run_period(P - 1, 0, 12, 4'hF, -1);
        n_checks++;
        if (hi[0] !== 10 || bad !== 0) begin
            n_fail++;
            $display("FAIL boundary_cur: ch0 %0d bad %0d required 10 0", hi[0], bad);
        end
        run_period(-1, 0, 0, 4'b1110, 50);
        n_checks++;
        if (hi[0] !== 12 || bad !== 0) begin
            n_fail++;
            $display("FAIL boundary_next: ch0 %0d bad %0d required 12 0", hi[0], bad);
        end
        run_period(-1, 0, 0, 4'hF, 10);
        n_checks++;
        if (hi[0] !== 0 || hi[2] !== 15 || bad !== 0) begin
            n_fail++;
            $display("FAIL disable: ch0 %0d ch2 %0d bad %0d required 0 15 0", hi[0], hi[2], bad);
        end
    endtask

    task automatic test_random;
        for (int r = 0; r < 8; r++) begin
            run_period(int'($urandom_range(0, P - 1)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 30)), 4'($urandom_range(0, 15)),
                       int'($urandom_range(0, P - 1)));
            n_checks++;
            if (bad !== 0) begin
                n_fail++;
                $display("FAIL random_model r%0d: %0d bad cycles, first p=%0d got %b required %b", r, bad, bad_p, bad_got, bad_exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        run_period(-1, 0, 0, 4'hF, 0);
        repeat (3) @(negedge clk);
        n_checks++;
        if (pwm_out !== 4'hF) begin
            n_fail++;
            $display("FAIL pre_reset_high: pwm %b required 1111", pwm_out);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (pwm_out !== 4'h0 || ledres !== 1'b1 || pwm3 !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset: pwm %b pwm3 %b ledres %b required 0000 000 1", pwm_out, pwm3, ledres);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_period(-1, 0, 0, 4'hF, -1);
        n_checks++;
        if (hi[0] + hi[1] + hi[2] + hi[3] !== 0 || bad !== 0) begin
            n_fail++;
            $display("FAIL post_reset_first: total high %0d bad %0d required 0 0", hi[0] + hi[1] + hi[2] + hi[3], bad);
        end
        run_period(-1, 0, 0, 4'hF, -1);
        for (int ch = 0; ch < 4; ch++) begin
            n_checks++;
            if (hi[ch] !== DEFP) begin
                n_fail++;
                $display("FAIL post_reset_width ch%0d: %0d required %0d", ch, hi[ch], DEFP);
            end
        end
    endtask

    initial begin
        test_reset;
        test_first_period;
        test_steady;
        test_write_mid;
        test_clamp;
        test_addr_err;
        test_boundary;
        test_random;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/servo_pwm_multi.md
# servo_pwm_multi

Multi-channel servo PWM generator: one shared period counter drives CHANNELS independent pulse outputs, each with its own programmable pulse width and enable. Pulse widths are written through a simple register-write port, clamped to a safe servo range, and applied glitch-free at period boundaries. It sits between the control logic (cube-move sequencer) and the servo pins, and replaces per-servo single-channel PWM instances.

## Interface
- CHANNELS, 4, number of servo outputs (1..16)
- CNT_W, 32, counter and pulse-width width in bits
- PERIOD, 1000000, PWM period in clk cycles (20 ms at 50 MHz); must be ≥ 2 and < 2^CNT_W
- MIN_PULSE, 50000, lowest allowed pulse width in cycles (1 ms)
- MAX_PULSE, 125000, highest allowed pulse width in cycles (2.5 ms); MIN_PULSE ≤ MAX_PULSE ≤ PERIOD
- DEFAULT_PULSE, 75000, pulse width after reset (1.5 ms, servo centre)
- AW, $clog2(CHANNELS) (min 1), write-address width
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  write strobe, one write per cycle
- wr_addr  in  AW  target channel index
- wr_data  in  CNT_W  requested pulse width in cycles
- ch_en  in  CHANNELS  per-channel enable request
- pwm_out  out  CHANNELS  servo pulse outputs
- period_start  out  1  one-cycle pulse at start of each period
- wr_clamped  out  1  one-cycle pulse: last write was clamped
- wr_err  out  1  one-cycle pulse: last write address out of range
- ledres  out  1  reset indicator

## Operation
- Period counter cnt: 0..PERIOD-1, increments every cycle, wraps PERIOD-1 → 0. No stall input.
- Per channel: pending width pend[ch], active width act[ch], active enable en_act[ch].
- Write (wr_en=1, wr_addr<CHANNELS): pend[wr_addr] ← clamp(wr_data); clamp = MIN_PULSE if below, MAX_PULSE if above, else unchanged. wr_clamped pulses if value altered.
- Write with wr_addr ≥ CHANNELS: no state change, wr_err pulses, wr_clamped stays 0.
- Boundary cycle (cnt = PERIOD-1): act[ch] ← pend[ch], en_act[ch] ← ch_en[ch] for all channels. Write on the boundary cycle bypasses: clamped wr_data goes directly into act[wr_addr] (and pend), effective for the next period.
- Writes and ch_en changes never alter the period in progress: no truncated or stretched pulses.
- Output: pwm_out[ch] registered from en_act[ch] && (cnt < act[ch]); high exactly act[ch] cycles per period when enabled, low all period when disabled.
- Comparisons unsigned, CNT_W bits; no overflow possible given parameter limits.
- ledres = 1 while reset asserted; 0 from the first clock edge after release.

## Timing
- Reset (async, reset=0): cnt=0, pend=act=DEFAULT_PULSE, en_act=0, pwm_out=0, period_start=0, wr_clamped=0, wr_err=0, ledres=1.
- First edge after release: cnt=0 → first edge registers period_start=1 and pwm_out from cnt=0; ch_en not yet latched, so outputs stay low until first boundary (en_act=0).
- pwm_out and period_start lag cnt by one cycle; period_start and rising pwm_out coincide.
- Write latency: wr_clamped/wr_err valid the cycle after wr_en; new width appears at pwm_out at start of the next period after the boundary.
- Reset mid-period: outputs drop to 0 immediately (asynchronous), all state reverts to reset values.
- Back-to-back writes to same channel within a period: last write before/at boundary wins.

## Test plan
- Params PERIOD=100, MIN=5, MAX=20, DEFAULT=10, CHANNELS=4. Release reset, ch_en=4'b1111 → first period all outputs low; from second period each pwm_out high 10 cycles per 100, period_start every 100 cycles aligned with rise.
- Write ch2=15 mid-period → current period ch2 still 10 cycles high; next period 15; other channels unchanged; wr_clamped=0.
- Write ch1=2, then ch3=50 → wr_clamped pulses both times; ch1 pulse 5, ch3 pulse 20 cycles.
- Write wr_addr=4 (AW=2 can't reach, use CHANNELS=3, addr=3) → wr_err pulse, no channel changes.
- Write ch0=12 exactly on cnt=99 boundary → ch0 pulse 12 in the immediately following period; drop ch_en[0] mid-period → current pulse completes, next period low.
- Assert reset mid-pulse → pwm_out=0 and ledres=1 without waiting for clk; after release widths back to 10.
